// File: rtl/vector_point_queue_pkg.sv
// vector_point_queue_pkg
//   Shared definitions for the vector endpoint queue:
//   - DEFAULT_BITS : default coordinate width (matches the line stepper)
//   - state_e      : queue FSM states (ST_DWELL used only when
//                    VECTOR_POINT_QUEUE_DWELL_EN is defined)
//   - point_width  : width of a packed point record {blank, y, x}
package vector_point_queue_pkg;

    localparam int unsigned DEFAULT_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT,
        ST_DWELL
    } state_e;

    // Point record layout is {blank, y[BITS-1:0], x[BITS-1:0]}
    function automatic int unsigned point_width(input int unsigned bits);
        return 2 * bits + 1;
    endfunction

endpackage

// File: rtl/vector_point_queue_if.sv
// vector_point_queue_if
//   Host write port plus stepper handshake for vector_point_queue.
//   master : host/stepper side (drives wr_*, ready, dwell)
//   slave  : queue side (drives full, count, overflow, strobe, x_in, y_in,
//            blank_out, idle)
//   Optional: VECTOR_POINT_QUEUE_DWELL_EN adds DWELL_BITS and the dwell input.
interface vector_point_queue_if
    import vector_point_queue_pkg::*;
#(
    parameter int unsigned BITS       = DEFAULT_BITS,
    parameter int unsigned DEPTH_LOG2 = 4
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
    , parameter int unsigned DWELL_BITS = 8
`endif
);

    logic                  wr_en;
    logic [BITS-1:0]       wr_x;
    logic [BITS-1:0]       wr_y;
    logic                  wr_blank;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  strobe;
    logic [BITS-1:0]       x_in;
    logic [BITS-1:0]       y_in;
    logic                  blank_out;
    logic                  ready;
    logic                  idle;
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
    logic [DWELL_BITS-1:0] dwell;
`endif

    modport master (
        output wr_en, wr_x, wr_y, wr_blank, ready,
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        output dwell,
`endif
        input  full, count, overflow, strobe, x_in, y_in, blank_out, idle
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_blank, ready,
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        input  dwell,
`endif
        output full, count, overflow, strobe, x_in, y_in, blank_out, idle
    );

endinterface

// File: rtl/vector_fifo.sv
// vector_fifo
//   Single-clock synchronous FIFO, 2**DEPTH_LOG2 entries of WIDTH bits.
//   Ports: clk, reset (async, active-high), push/wr_data, pop/rd_data
//   (rd_data shows the head entry), full, empty, count.
//   Pushes while full are rejected even if a pop happens the same cycle.
module vector_fifo
    import vector_point_queue_pkg::*;
#(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    assign full    = count_q[DEPTH_LOG2];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            if (do_push && !do_pop)
                count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
            else if (!do_push && do_pop)
                count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/vector_point_queue.sv
// vector_point_queue
//   Buffers host-written (x, y, blank) endpoints and feeds them one at a
//   time to the Bresenham stepper, waiting for its ready between points.
//   Ports: clk, reset (async, active-high), bus (vector_point_queue_if.slave):
//     wr_en/wr_x/wr_y/wr_blank host writes; full/count/overflow status;
//     strobe/x_in/y_in/blank_out to stepper; ready from stepper; idle.
//   Optional: VECTOR_POINT_QUEUE_DWELL_EN adds a DWELL state that holds
//   dwell+1 cycles at each endpoint (dwell input on the bus).
module vector_point_queue
    import vector_point_queue_pkg::*;
#(
    parameter int unsigned BITS       = DEFAULT_BITS,
    parameter int unsigned DEPTH_LOG2 = 4
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
    , parameter int unsigned DWELL_BITS = 8
`endif
) (
    input logic           clk,
    input logic           reset,
    vector_point_queue_if.slave bus
);

    localparam int unsigned PW = point_width(BITS);

    state_e          state_q;
    logic            strobe_q;
    logic            blank_q;
    logic            overflow_q;
    logic [BITS-1:0] x_q;
    logic [BITS-1:0] y_q;
    logic [PW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
    logic [DWELL_BITS-1:0] dwell_cnt_q;
`endif

    assign pop = (state_q == ST_IDLE) && !fifo_empty && bus.ready;

    vector_fifo #(
        .WIDTH      (PW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.wr_en),
        .wr_data ({bus.wr_blank, bus.wr_y, bus.wr_x}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.count)
    );

    // Outputs are loaded on the IDLE->ISSUE edge so they are valid
    // for exactly the ISSUE cycle in which strobe is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            strobe_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            blank_q    <= 1'b1;
            overflow_q <= 1'b0;
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
            dwell_cnt_q <= '0;
`endif
        end else begin
            strobe_q <= 1'b0;
            if (bus.wr_en && fifo_full) overflow_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q  <= ST_ISSUE;
                        strobe_q <= 1'b1;
                        x_q      <= head[BITS-1:0];
                        y_q      <= head[2*BITS-1:BITS];
                        blank_q  <= head[2*BITS];
                    end
                end
                ST_ISSUE:  state_q <= ST_SETTLE;
                // ready seen here still reflects the old destination.
                ST_SETTLE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.ready) begin
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
                        dwell_cnt_q <= bus.dwell;
                        state_q     <= ST_DWELL;
`else
                        state_q     <= ST_IDLE;
`endif
                    end
                end
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
                ST_DWELL: begin
                    if (dwell_cnt_q == '0) state_q <= ST_IDLE;
                    else dwell_cnt_q <= dwell_cnt_q - DWELL_BITS'(1);
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.full      = fifo_full;
    assign bus.overflow  = overflow_q;
    assign bus.strobe    = strobe_q;
    assign bus.x_in      = x_q;
    assign bus.y_in      = y_q;
    assign bus.blank_out = blank_q;
    assign bus.idle      = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_vector_point_queue.sv
// tb_vector_point_queue
//   Self-checking bench for vector_point_queue (DEPTH_LOG2 = 2).
//   A small stepper model drives ready: it stays low for seg_len cycles
//   after each strobe (optionally one cycle late when stale_mode is set).
module tb_vector_point_queue;

    localparam int unsigned BITS = 16;
    localparam int unsigned DL2  = 2;

    typedef struct {
        logic [BITS-1:0] x;
        logic [BITS-1:0] y;
        logic            blank;
    } point_t;

    typedef struct {
        logic [BITS-1:0] x;
        logic [BITS-1:0] y;
        logic            blank;
        logic            accept;
        logic            exp_full;
        int unsigned     exp_count;
        logic            exp_ovf;
    } wr_vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_point_queue_if #(
        .BITS       (BITS),
        .DEPTH_LOG2 (DL2)
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        , .DWELL_BITS (8)
`endif
    ) bus ();

    vector_point_queue #(
        .BITS       (BITS),
        .DEPTH_LOG2 (DL2)
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        , .DWELL_BITS (8)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    point_t sb[$];
    int n_checks    = 0;
    int n_pass      = 0;
    int n_strobes   = 0;
    int cyc         = 0;
    int last_strobe = -1;
    int seg_len     = 0;
    int dwell_val   = 0;
    int busy_q      = 0;
    logic hold_ready = 1'b0;
    logic stale_mode = 1'b0;
    logic lag_q      = 1'b0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Strobe-to-strobe spacing: WAIT sees ready no earlier than 2 cycles
    // after the strobe, then one IDLE cycle, plus dwell+1 DWELL cycles.
    function automatic int exp_gap();
        int l;
        l = (seg_len < 1) ? 1 : seg_len;
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        return l + 3 + dwell_val + 1;
`else
        return l + 3;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stepper model
    always @(posedge clk) begin
        if (bus.strobe) begin
            lag_q  <= stale_mode;
            busy_q <= seg_len;
        end else begin
            lag_q <= 1'b0;
            if (busy_q > 0) busy_q <= busy_q - 1;
        end
    end
    assign bus.ready = !hold_ready && (busy_q == 0 || lag_q);

    // Strobe monitor / scoreboard consumer
    always @(negedge clk) begin : monitor
        point_t p;
        if (bus.strobe) begin
            n_strobes++;
            if (last_strobe >= 0) chk("strobe_gap", cyc - last_strobe, exp_gap());
            last_strobe = cyc;
            chk("strobe_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                p = sb.pop_front();
                chk("x_in", bus.x_in, p.x);
                chk("y_in", bus.y_in, p.y);
                chk("blank_out", bus.blank_out, p.blank);
            end
        end
    end

    task automatic write_pt(input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                            input logic b, input logic push_sb);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_x     = x;
        bus.wr_y     = y;
        bus.wr_blank = b;
        if (push_sb) sb.push_back('{x: x, y: y, blank: b});
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(bus.idle && sb.size() == 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, (k < budget), 1);
    endtask

    task automatic wait_strobes(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (n_strobes < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, (n_strobes >= target), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_strobe"},   bus.strobe,    0);
        chk({tag, "_x_in"},     bus.x_in,      0);
        chk({tag, "_y_in"},     bus.y_in,      0);
        chk({tag, "_blank"},    bus.blank_out, 1);
        chk({tag, "_count"},    bus.count,     0);
        chk({tag, "_full"},     bus.full,      0);
        chk({tag, "_overflow"}, bus.overflow,  0);
        chk({tag, "_idle"},     bus.idle,      1);
    endtask

    initial begin
        wr_vec_t tbl[5];
        int base;

        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_x     = '0;
        bus.wr_y     = '0;
        bus.wr_blank = 1'b0;
`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        bus.dwell    = '0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;

        // Basic two-point sequence
        seg_len = 50; last_strobe = -1; base = n_strobes;
        write_pt(16'd10000, 16'd3000, 1'b0, 1'b1);
        write_pt(16'd3000, 16'd10000, 1'b1, 1'b1);
        wait_idle("basic_done", 400);
        chk("basic_strobes", n_strobes - base, 2);
        chk("basic_blank_held", bus.blank_out, 1);
        chk("basic_x_held", bus.x_in, 3000);

        // Stale ready in the settle cycle must not shorten the segment
        seg_len = 5; stale_mode = 1'b1; last_strobe = -1; base = n_strobes;
        write_pt(16'd5, 16'd5, 1'b0, 1'b1);
        write_pt(16'd7, 16'd9, 1'b1, 1'b1);
        wait_idle("stale_done", 200);
        chk("stale_strobes", n_strobes - base, 2);
        stale_mode = 1'b0;

        // Fill / overflow with the stepper stalled
        hold_ready = 1'b1; seg_len = 3; last_strobe = -1; base = n_strobes;
        tbl[0] = '{x: 100, y: 200, blank: 0, accept: 1, exp_full: 0, exp_count: 1, exp_ovf: 0};
        tbl[1] = '{x: 101, y: 201, blank: 1, accept: 1, exp_full: 0, exp_count: 2, exp_ovf: 0};
        tbl[2] = '{x: 102, y: 202, blank: 0, accept: 1, exp_full: 0, exp_count: 3, exp_ovf: 0};
        tbl[3] = '{x: 103, y: 203, blank: 1, accept: 1, exp_full: 1, exp_count: 4, exp_ovf: 0};
        tbl[4] = '{x: 104, y: 204, blank: 0, accept: 0, exp_full: 1, exp_count: 4, exp_ovf: 1};
        for (int i = 0; i < 5; i++) begin
            write_pt(tbl[i].x, tbl[i].y, tbl[i].blank, tbl[i].accept);
            chk($sformatf("tbl%0d_full", i),     bus.full,     tbl[i].exp_full);
            chk($sformatf("tbl%0d_count", i),    bus.count,    tbl[i].exp_count);
            chk($sformatf("tbl%0d_overflow", i), bus.overflow, tbl[i].exp_ovf);
        end
        hold_ready = 1'b0;
        wait_idle("full_drain", 200);
        chk("full_strobes", n_strobes - base, 4);
        chk("overflow_sticky", bus.overflow, 1);

        // Back-to-back zero-length points
        seg_len = 0; last_strobe = -1; base = n_strobes;
        for (int i = 0; i < 3; i++) write_pt(16'd0, 16'd0, 1'b0, 1'b1);
        wait_idle("zero_done", 100);
        chk("zero_strobes", n_strobes - base, 3);

`ifdef VECTOR_POINT_QUEUE_DWELL_EN
        // Dwell at each endpoint
        seg_len = 20; dwell_val = 7; bus.dwell = 8'd7; last_strobe = -1; base = n_strobes;
        write_pt(16'd40, 16'd50, 1'b0, 1'b1);
        write_pt(16'd60, 16'd70, 1'b1, 1'b1);
        wait_idle("dwell_done", 200);
        chk("dwell_strobes", n_strobes - base, 2);
        dwell_val = 0; bus.dwell = '0;
`endif

        // Asynchronous reset while waiting on a segment
        seg_len = 50; last_strobe = -1; base = n_strobes;
        write_pt(16'd1234, 16'd4321, 1'b0, 1'b1);
        write_pt(16'd2, 16'd3, 1'b1, 1'b1);
        write_pt(16'd4, 16'd5, 1'b0, 1'b1);
        wait_strobes("areset_first_strobe", base + 1, 50);
        repeat (10) @(negedge clk);
        chk("pre_rst_count", bus.count, 2);
        chk("pre_rst_x_in", bus.x_in, 1234);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_state("areset");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        base = n_strobes;
        repeat (100) @(negedge clk);
        chk("post_rst_no_strobe", n_strobes - base, 0);
        chk("post_rst_idle", bus.idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
